// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 8-bit multi-cycle ALU: request FIFO, begin/end sequencing, response hold.
// Optional watchdog on the ALU wait is enabled by defining ALU_ISSUE_TIMEOUT_EN.
module alu_issue_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [1:0]                   req_op,
  input  logic [7:0]                   req_x,
  input  logic [7:0]                   req_y,
  input  logic [7:0]                   req_a,
  output logic [7:0]                   alu_x,
  output logic [7:0]                   alu_y,
  output logic [7:0]                   alu_a_divide,
  output logic [1:0]                   alu_op,
  output logic                         alu_begin,
  input  logic                         alu_end,
  input  logic [15:0]                  alu_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [15:0]                  rsp_data,
  output logic [1:0]                   rsp_op,
  output logic                         rsp_err,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("alu_issue_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t         state_q, state_d;
  logic [25:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [1:0]     op_q, op_d;
  logic [7:0]     x_q, x_d;
  logic [7:0]     y_q, y_d;
  logic [7:0]     a_q, a_d;
  logic [15:0]    rsp_data_q, rsp_data_d;
  logic [1:0]     rsp_op_q, rsp_op_d;
  logic           full, empty, push, pop;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = req_valid && !full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_op, req_x, req_y, req_a};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    a_d        = a_q;
    rsp_data_d = rsp_data_q;
    rsp_op_d   = rsp_op_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop                    = 1'b1;
          {op_d, x_d, y_d, a_d}  = mem_q[rd_ptr_q];
          state_d                = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ALU_ISSUE_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        // A real completion takes priority over the watchdog on the limit cycle.
        if (alu_end) begin
          rsp_data_d = alu_out;
          rsp_op_d   = op_q;
          state_d    = S_HOLD;
`ifdef ALU_ISSUE_TIMEOUT_EN
          rsp_err_d  = 1'b0;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = '1;
          rsp_op_d   = op_q;
          rsp_err_d  = 1'b1;
          state_d    = S_HOLD;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + TW'(1);
`endif
        end
      end
      S_HOLD: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      a_q        <= '0;
      rsp_data_q <= '0;
      rsp_op_q   <= '0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      a_q        <= a_d;
      rsp_data_q <= rsp_data_d;
      rsp_op_q   <= rsp_op_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

`ifdef ALU_ISSUE_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready    = !full;
  assign alu_begin    = (state_q == S_ISSUE);
  assign rsp_valid    = (state_q == S_HOLD);
  assign busy         = (state_q != S_IDLE) || !empty;
  assign fifo_count   = count_q;
  assign alu_x        = x_q;
  assign alu_y        = y_q;
  assign alu_a_divide = a_q;
  assign alu_op       = op_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_op       = rsp_op_q;

endmodule
